// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the three-requester single-port RAM arbiter.
// Holds the requester and FSM encodings and the default starvation limit.
package mem_port_arbiter_pkg;

    localparam int STARVE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        REQ_DBG  = 2'd0,
        REQ_DAT  = 2'd1,
        REQ_IFU  = 2'd2,
        REQ_NONE = 2'd3
    } req_e;

    typedef enum logic [1:0] {
        ST_ARB        = 2'd0,
        ST_LOCK_DRAIN = 2'd1,
        ST_LOCKED     = 2'd2
    } state_e;

    // One-hot grant (bit0 dbg, bit1 dat, bit2 ifu) to requester id.
    function automatic req_e grant_to_req(input logic [2:0] grant);
        req_e id;
        id = REQ_NONE;
        if (grant[0])
            id = REQ_DBG;
        else if (grant[1])
            id = REQ_DAT;
        else if (grant[2])
            id = REQ_IFU;
        return id;
    endfunction

endpackage

// File: rtl/mem_arb_prio_sel.sv
// Combinational priority selector: valids + FSM state + promote flag -> one-hot grant.
// Grant bit order: [0] dbg, [1] dat, [2] ifu.
module mem_arb_prio_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic       i_dbg_valid,
    input  logic       i_dat_valid,
    input  logic       i_ifu_valid,
    input  logic [1:0] i_state,
    input  logic       i_promote,
    output logic [2:0] o_grant
);

    state_e w_state;
    assign w_state = state_e'(i_state);

    always_comb begin
        o_grant = 3'b000;
        if (w_state != ST_ARB) begin
            // Drain and locked phases belong to the debugger alone.
            if (i_dbg_valid)
                o_grant = 3'b001;
        end else if (i_dbg_valid) begin
            o_grant = 3'b001;
        end else if (i_promote && i_ifu_valid) begin
            o_grant = 3'b100;
        end else if (i_dat_valid) begin
            o_grant = 3'b010;
        end else if (i_ifu_valid) begin
            o_grant = 3'b100;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates dbg/dat/ifu onto one RAM port with a debug lock FSM and 1-cycle responses.
// Optional ifu starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic [ADDR_WIDTH-3:0] dbg_req_addr,
    input  logic                  dbg_req_we,
    input  logic [3:0]            dbg_req_be,
    input  logic [31:0]           dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    output logic [31:0]           dbg_rsp_rdata,

    input  logic                  dat_req_valid,
    output logic                  dat_req_ready,
    input  logic [ADDR_WIDTH-3:0] dat_req_addr,
    input  logic                  dat_req_we,
    input  logic [3:0]            dat_req_be,
    input  logic [31:0]           dat_req_wdata,
    output logic                  dat_rsp_valid,
    output logic [31:0]           dat_rsp_rdata,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-3:0] ifu_req_addr,
    output logic                  ifu_rsp_valid,
    output logic [31:0]           ifu_rsp_rdata,

    input  logic                  dbg_lock,
    output logic                  dbg_lock_ack,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be within 1..255");
    end

    state_e      r_state;
    req_e        r_rsp_owner_p1;
    logic        r_rsp_we_p1;
    state_e      w_eff_state;
    logic [2:0]  w_sel;
    logic [2:0]  w_gnt;
    logic        w_promote;
    logic [31:0] w_rsp_data;

    // A locked debugger that releases the lock hands the port back in the same cycle.
    assign w_eff_state = (r_state == ST_LOCKED && !dbg_lock) ? ST_ARB : r_state;

    mem_arb_prio_sel u_prio_sel (
        .i_dbg_valid (dbg_req_valid),
        .i_dat_valid (dat_req_valid),
        .i_ifu_valid (ifu_req_valid),
        .i_state     (w_eff_state),
        .i_promote   (w_promote),
        .o_grant     (w_sel)
    );

    assign w_gnt         = rst ? 3'b000 : w_sel;
    assign dbg_req_ready = w_gnt[0];
    assign dat_req_ready = w_gnt[1];
    assign ifu_req_ready = w_gnt[2];
    assign dbg_lock_ack  = !rst && (r_state == ST_LOCKED) && dbg_lock;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [7:0] r_starve_cnt;

    assign w_promote = (r_starve_cnt >= 8'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst)
            r_starve_cnt <= 8'd0;
        else if (!ifu_req_valid || w_gnt[2])
            r_starve_cnt <= 8'd0;
        else if (w_eff_state == ST_ARB && r_starve_cnt != 8'hFF)
            r_starve_cnt <= r_starve_cnt + 8'd1;
    end
`else
    assign w_promote = 1'b0;
`endif

    // Request stage: RAM port mirrors the granted requester.
    always_comb begin
        mem_en    = |w_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'h0;
        mem_wdata = 32'd0;
        if (w_gnt[0]) begin
            mem_we    = dbg_req_we;
            mem_addr  = dbg_req_addr;
            mem_be    = dbg_req_be;
            mem_wdata = dbg_req_wdata;
        end else if (w_gnt[1]) begin
            mem_we    = dat_req_we;
            mem_addr  = dat_req_addr;
            mem_be    = dat_req_be;
            mem_wdata = dat_req_wdata;
        end else if (w_gnt[2]) begin
            mem_addr  = ifu_req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rsp_owner_p1 <= REQ_NONE;
        else
            r_rsp_owner_p1 <= grant_to_req(w_gnt);
        r_rsp_we_p1 <= mem_we;
    end

    // Response stage: RAM data lands one cycle after the grant.
    assign w_rsp_data    = r_rsp_we_p1 ? 32'd0 : mem_rdata;
    assign dbg_rsp_valid = !rst && (r_rsp_owner_p1 == REQ_DBG);
    assign dat_rsp_valid = !rst && (r_rsp_owner_p1 == REQ_DAT);
    assign ifu_rsp_valid = !rst && (r_rsp_owner_p1 == REQ_IFU);
    assign dbg_rsp_rdata = dbg_rsp_valid ? w_rsp_data : 32'd0;
    assign dat_rsp_rdata = dat_rsp_valid ? w_rsp_data : 32'd0;
    assign ifu_rsp_rdata = ifu_rsp_valid ? w_rsp_data : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ARB;
        end else begin
            case (r_state)
                ST_ARB:
                    if (dbg_lock)
                        r_state <= ST_LOCK_DRAIN;
                // Only dbg is granted while draining, and any dat/ifu response
                // still in flight completes in this cycle.
                ST_LOCK_DRAIN:
                    r_state <= dbg_lock ? ST_LOCKED : ST_ARB;
                ST_LOCKED:
                    if (!dbg_lock)
                        r_state <= ST_ARB;
                default:
                    r_state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: RAM model, response scoreboard, scenario tasks.
module tb_mem_port_arbiter;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          dbg_req_valid, dbg_req_ready, dbg_req_we, dbg_rsp_valid;
    logic [AW-1:0] dbg_req_addr;
    logic [3:0]    dbg_req_be;
    logic [31:0]   dbg_req_wdata, dbg_rsp_rdata;
    logic          dat_req_valid, dat_req_ready, dat_req_we, dat_rsp_valid;
    logic [AW-1:0] dat_req_addr;
    logic [3:0]    dat_req_be;
    logic [31:0]   dat_req_wdata, dat_rsp_rdata;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [AW-1:0] ifu_req_addr;
    logic [31:0]   ifu_rsp_rdata;
    logic          dbg_lock, dbg_lock_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
        .dbg_req_we(dbg_req_we), .dbg_req_be(dbg_req_be), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
        .dat_req_valid(dat_req_valid), .dat_req_ready(dat_req_ready), .dat_req_addr(dat_req_addr),
        .dat_req_we(dat_req_we), .dat_req_be(dat_req_be), .dat_req_wdata(dat_req_wdata),
        .dat_rsp_valid(dat_rsp_valid), .dat_rsp_rdata(dat_rsp_rdata),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
        .dbg_lock(dbg_lock), .dbg_lock_ack(dbg_lock_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hA5, b, 8'h3C, ~b};
    endfunction

    // RAM behind the port: reset reloads a known pattern.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    typedef struct {
        int          who;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [0:255];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Pops the response expected this cycle and pushes the one produced by this cycle's grant.
    task automatic scoreboard();
        exp_t        e;
        logic [2:0]  rv, erv, hs;
        logic [31:0] got;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 256; i++) model[i] = init_word(i);
        end else begin
            e.who = 3;
            e.data = 32'd0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            rv  = {ifu_rsp_valid, dat_rsp_valid, dbg_rsp_valid};
            erv = (e.who < 3) ? 3'(1 << e.who) : 3'b000;
            checks++;
            if (rv !== erv) begin
                errors++;
                $display("FAIL sb_rsp_valid t=%0t got %b required %b", $time, rv, erv);
            end
            if (e.who < 3) begin
                got = (e.who == 0) ? dbg_rsp_rdata : (e.who == 1) ? dat_rsp_rdata : ifu_rsp_rdata;
                checks++;
                if (got !== e.data) begin
                    errors++;
                    $display("FAIL sb_rsp_rdata t=%0t who=%0d got %h required %h", $time, e.who, got, e.data);
                end
            end
            hs = {ifu_req_valid & ifu_req_ready, dat_req_valid & dat_req_ready,
                  dbg_req_valid & dbg_req_ready};
            checks++;
            if (!$onehot0(hs) || mem_en !== (|hs)) begin
                errors++;
                $display("FAIL sb_grant t=%0t handshakes %b mem_en %b", $time, hs, mem_en);
            end
            e.who = 3;
            e.data = 32'd0;
            if (hs[0] || hs[1]) begin
                e.who = hs[0] ? 0 : 1;
                checks++;
                if (hs[0] ? ({mem_we, mem_addr} !== {dbg_req_we, dbg_req_addr} ||
                             (dbg_req_we && {mem_be, mem_wdata} !== {dbg_req_be, dbg_req_wdata}))
                          : ({mem_we, mem_addr} !== {dat_req_we, dat_req_addr} ||
                             (dat_req_we && {mem_be, mem_wdata} !== {dat_req_be, dat_req_wdata}))) begin
                    errors++;
                    $display("FAIL sb_mem_fields t=%0t who=%0d got we=%b addr=%h be=%h wd=%h",
                             $time, e.who, mem_we, mem_addr, mem_be, mem_wdata);
                end
                if (hs[0] && dbg_req_we)
                    model[dbg_req_addr[7:0]] = merge(model[dbg_req_addr[7:0]], dbg_req_wdata, dbg_req_be);
                else if (hs[1] && dat_req_we)
                    model[dat_req_addr[7:0]] = merge(model[dat_req_addr[7:0]], dat_req_wdata, dat_req_be);
                else
                    e.data = model[hs[0] ? dbg_req_addr[7:0] : dat_req_addr[7:0]];
            end else if (hs[2]) begin
                e.who = 2;
                e.data = model[ifu_req_addr[7:0]];
                checks++;
                if ({mem_we, mem_addr} !== {1'b0, ifu_req_addr}) begin
                    errors++;
                    $display("FAIL sb_mem_fields t=%0t ifu got we=%b addr=%h required addr %h",
                             $time, mem_we, mem_addr, ifu_req_addr);
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic neg();
        @(negedge clk);
        scoreboard();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dbg_req_valid = 0; dbg_req_addr = '0; dbg_req_we = 0; dbg_req_be = 4'h0; dbg_req_wdata = 32'd0;
        dat_req_valid = 0; dat_req_addr = '0; dat_req_we = 0; dat_req_be = 4'h0; dat_req_wdata = 32'd0;
        ifu_req_valid = 0; ifu_req_addr = '0;
        dbg_lock = 0;
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        rst = 1;
        dbg_req_valid = 1; dat_req_valid = 1; ifu_req_valid = 1; dbg_lock = 1;
        for (int k = 0; k < 3; k++) begin
            neg();
            outs = {dbg_req_ready, dat_req_ready, ifu_req_ready, dbg_rsp_valid, dat_rsp_valid,
                    ifu_rsp_valid, mem_en, mem_we, dbg_lock_ack, |{dbg_rsp_rdata, dat_rsp_rdata},
                    |ifu_rsp_rdata};
            checks++;
            if (outs !== 11'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got %b required 0", k, outs);
            end
            pos();
        end
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_three_reads();
        logic [2:0]  g, rv;
        logic [31:0] rd;
        logic [7:0]  a;
        dbg_req_valid = 1; dbg_req_addr = 30'h10;
        dat_req_valid = 1; dat_req_addr = 30'h20;
        ifu_req_valid = 1; ifu_req_addr = 30'h30;
        for (int k = 0; k < 4; k++) begin
            neg();
            g = {ifu_req_valid & ifu_req_ready, dat_req_valid & dat_req_ready, dbg_req_valid & dbg_req_ready};
            checks++;
            if (g !== ((k < 3) ? 3'(1 << k) : 3'b000)) begin
                errors++;
                $display("FAIL three_reads_grant cycle=%0d got %b required %b", k, g,
                         (k < 3) ? 3'(1 << k) : 3'b000);
            end
            if (k > 0) begin
                rv = {ifu_rsp_valid, dat_rsp_valid, dbg_rsp_valid};
                rd = (k == 1) ? dbg_rsp_rdata : (k == 2) ? dat_rsp_rdata : ifu_rsp_rdata;
                a  = 8'(k * 16);
                checks++;
                if (rv !== 3'(1 << (k - 1)) || rd !== init_word(int'(a))) begin
                    errors++;
                    $display("FAIL three_reads_rsp cycle=%0d got valid %b data %h required %b %h",
                             k, rv, rd, 3'(1 << (k - 1)), init_word(int'(a)));
                end
            end
            pos();
            if (k == 0) dbg_req_valid = 0;
            if (k == 1) dat_req_valid = 0;
            if (k == 2) ifu_req_valid = 0;
        end
    endtask

    task automatic test_write_then_read();
        dat_req_valid = 1; dat_req_we = 1; dat_req_be = 4'hF; dat_req_addr = 30'h40; dat_req_wdata = 32'hDEADBEEF;
        neg();
        checks++;
        if (!(dat_req_ready === 1'b1 && mem_we === 1'b1 && mem_wdata === 32'hDEADBEEF)) begin
            errors++;
            $display("FAIL wr_grant got ready=%b we=%b wd=%h required 1 1 deadbeef", dat_req_ready, mem_we, mem_wdata);
        end
        pos();
        dat_req_valid = 0; dat_req_we = 0;
        ifu_req_valid = 1; ifu_req_addr = 30'h40;
        neg();
        checks++;
        if (dat_rsp_valid !== 1'b1 || dat_rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL wr_rsp got valid=%b data=%h required 1 00000000", dat_rsp_valid, dat_rsp_rdata);
        end
        pos();
        ifu_req_valid = 0;
        dbg_req_valid = 1; dbg_req_we = 1; dbg_req_be = 4'b0011; dbg_req_addr = 30'h40; dbg_req_wdata = 32'h12345678;
        neg();
        checks++;
        if (ifu_rsp_valid !== 1'b1 || ifu_rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_after_wr got valid=%b data=%h required 1 deadbeef", ifu_rsp_valid, ifu_rsp_rdata);
        end
        pos();
        dbg_req_valid = 0; dbg_req_we = 0;
        dat_req_valid = 1; dat_req_addr = 30'h40;
        neg();
        pos();
        dat_req_valid = 0;
        neg();
        checks++;
        if (dat_rsp_valid !== 1'b1 || dat_rsp_rdata !== 32'hDEAD5678) begin
            errors++;
            $display("FAIL partial_be got valid=%b data=%h required 1 dead5678", dat_rsp_valid, dat_rsp_rdata);
        end
        pos();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                ifu_req_valid = 0;
                dbg_req_valid = 1; dbg_req_we = 1; dbg_req_be = 4'hF;
                dbg_req_addr = 30'(8'h80 + i); dbg_req_wdata = $urandom;
            end else begin
                dbg_req_valid = 0; dbg_req_we = 0;
                ifu_req_valid = 1; ifu_req_addr = 30'(8'h80 + i - 1);
            end
            neg();
            checks++;
            if (mem_en !== 1'b1) begin
                errors++;
                $display("FAIL b2b_mem_en cycle=%0d got %b required 1", i, mem_en);
            end
            pos();
        end
        idle_inputs();
    endtask

    task automatic test_priority_guard();
        logic [2:0] g, want;
        dat_req_valid = 1; dat_req_addr = 30'h50;
        ifu_req_valid = 1; ifu_req_addr = 30'h60;
        for (int k = 0; k < 10; k++) begin
            neg();
            g = {ifu_req_ready, dat_req_ready, dbg_req_ready};
`ifdef MEM_ARB_STARVE_GUARD_EN
            want = (k == 4 || k == 9) ? 3'b100 : 3'b010;
`else
            want = 3'b010;
`endif
            checks++;
            if (g !== want) begin
                errors++;
                $display("FAIL starve_grant cycle=%0d got %b required %b", k, g, want);
            end
            pos();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        dat_req_valid = 1; dat_req_addr = 30'h20; dbg_lock = 1;
        neg();
        checks++;
        if (dat_req_ready !== 1'b1 || dbg_lock_ack !== 1'b0) begin
            errors++;
            $display("FAIL lock_entry got ready=%b ack=%b required 1 0", dat_req_ready, dbg_lock_ack);
        end
        pos();
        dat_req_addr = 30'h21; ifu_req_valid = 1; ifu_req_addr = 30'h30;
        neg();
        checks++;
        if (dat_rsp_valid !== 1'b1 || dat_rsp_rdata !== init_word(32'h20) || dbg_lock_ack !== 1'b0 ||
            {dat_req_ready, ifu_req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL lock_drain got rsp=%b data=%h ack=%b ready=%b%b", dat_rsp_valid, dat_rsp_rdata,
                     dbg_lock_ack, dat_req_ready, ifu_req_ready);
        end
        pos();
        dbg_req_valid = 1; dbg_req_addr = 30'h10;
        for (int k = 0; k < 20; k++) begin
            neg();
            checks++;
            if (dbg_lock_ack !== 1'b1 || {dat_req_ready, ifu_req_ready} !== 2'b00 ||
                (k == 0 && dbg_req_ready !== 1'b1)) begin
                errors++;
                $display("FAIL locked cycle=%0d got ack=%b ready dbg/dat/ifu=%b%b%b", k, dbg_lock_ack,
                         dbg_req_ready, dat_req_ready, ifu_req_ready);
            end
            pos();
            dbg_req_valid = 0;
        end
        dbg_lock = 0;
        neg();
        checks++;
        if (dbg_lock_ack !== 1'b0 || dat_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL unlock got ack=%b dat_ready=%b required 0 1", dbg_lock_ack, dat_req_ready);
        end
        pos();
        idle_inputs();
    endtask

    task automatic test_lock_abort();
        dbg_lock = 1;
        neg();
        pos();
        dbg_lock = 0; dat_req_valid = 1; dat_req_addr = 30'h22;
        neg();
        checks++;
        if (dbg_lock_ack !== 1'b0 || dat_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain got ack=%b dat_ready=%b required 0 0", dbg_lock_ack, dat_req_ready);
        end
        pos();
        neg();
        checks++;
        if (dbg_lock_ack !== 1'b0 || dat_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_arb got ack=%b dat_ready=%b required 0 1", dbg_lock_ack, dat_req_ready);
        end
        pos();
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        ifu_req_valid = 1; ifu_req_addr = 30'h30;
        neg();
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant got %b required 1", ifu_req_ready);
        end
        pos();
        rst = 1; dat_req_valid = 1;
        neg();
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_rdata, ifu_req_ready, dat_req_ready, mem_en, mem_we, dbg_lock_ack} !== 37'd0) begin
            errors++;
            $display("FAIL midrst_outputs got rsp=%b data=%h ready=%b%b mem_en=%b", ifu_rsp_valid, ifu_rsp_rdata,
                     ifu_req_ready, dat_req_ready, mem_en);
        end
        pos();
        rst = 0;
        idle_inputs();
        neg();
        checks++;
        if ({dbg_rsp_valid, dat_rsp_valid, ifu_rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_after got %b required 000", {dbg_rsp_valid, dat_rsp_valid, ifu_rsp_valid});
        end
        pos();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        pos();
        test_reset();
        test_three_reads();
        test_write_then_read();
        test_back_to_back();
        test_priority_guard();
        test_lock();
        test_lock_abort();
        test_reset_midflight();
        test_three_reads();
        neg();
        pos();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 32, physical byte-address width; request addresses are word addresses of ADDR_WIDTH-2 bits.
REQ-002 Parameter STARVE_LIMIT, 8, consecutive lost arbitrations before ifu is promoted (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 <p>_req_valid  input  1  request present; p in {dbg, dat, ifu}.
REQ-006 <p>_req_ready  output  1  request accepted this cycle.
REQ-007 <p>_req_addr  input  ADDR_WIDTH-2  word address.
REQ-008 <p>_req_we, <p>_req_be, <p>_req_wdata  input  1/4/32  write enable, byte enables, write data; p in {dbg, dat} only, since ifu is read-only.
REQ-009 <p>_rsp_valid  output  1  response for the accepted request; <p>_rsp_rdata  output  32  read data.
REQ-010 dbg_lock  input  1  debug requests exclusive ownership of the RAM port.
REQ-011 dbg_lock_ack  output  1  exclusive ownership granted to dbg.
REQ-012 mem_en, mem_we  output  1  RAM port strobes.
REQ-013 mem_addr  output  ADDR_WIDTH-2  RAM word address.
REQ-014 mem_be, mem_wdata  output  4/32  RAM byte enables and write data.
REQ-015 mem_rdata  input  32  RAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-016 At most one <p>_req_ready is high per cycle; it is combinational from the valids and the state, and a handshake is valid&ready.
REQ-017 mem_en equals the OR of the accepted handshakes; mem_* fields mirror the granted requester in the same cycle.
REQ-018 Priority in state ARB: dbg > dat > ifu.
REQ-019 Every accepted request, read or write, produces exactly one <p>_rsp_valid pulse, exactly 1 cycle later, to the same requester; rsp_rdata is mem_rdata for reads and 0 for writes.
REQ-020 Back-to-back grants to any mix of requesters are allowed every cycle, so peak throughput is 1 request per cycle.
REQ-021 The FSM has states ARB, LOCK_DRAIN and LOCKED.
REQ-022 ARB to LOCK_DRAIN when dbg_lock=1; LOCK_DRAIN grants dbg only; the transition to LOCKED occurs the cycle after entry, once no non-dbg response is outstanding.
REQ-023 LOCKED asserts dbg_lock_ack and grants dbg only; dat and ifu see ready=0.
REQ-024 LOCKED to ARB on the first cycle dbg_lock=0; dbg_lock_ack drops in that same cycle.
REQ-025 If dbg_lock drops during LOCK_DRAIN, the FSM returns to ARB without asserting dbg_lock_ack.
REQ-026 A request held without acceptance keeps its payload stable; the arbiter does not check this.

Reset
REQ-027 While rst=1: all req_ready=0, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, dbg_lock_ack=0, FSM=ARB, starvation counter=0.
REQ-028 A response pending when rst rises is discarded; no rsp_valid is asserted in the cycle after rst deasserts.

Configuration
REQ-029 Macro MEM_ARB_STARVE_GUARD_EN defined: an 8-bit counter increments on each ARB cycle where ifu_req_valid=1 and ifu is not granted, and resets to 0 on an ifu grant or when ifu_req_valid=0.
REQ-030 With MEM_ARB_STARVE_GUARD_EN defined, when the counter reaches STARVE_LIMIT, ifu takes priority over dat (not over dbg) for exactly one grant.
REQ-031 Macro undefined: no counter is present, and priority is strictly fixed per REQ-018.

Structure
REQ-032 Package mem_port_arbiter_pkg holds the requester enum (REQ_DBG, REQ_DAT, REQ_IFU, REQ_NONE), the FSM state enum and the STARVE_LIMIT default.
REQ-033 One combinational sub-module, mem_arb_prio_sel, maps valids, state and promote flag to a one-hot grant; the response owner register and the FSM stay in mem_port_arbiter.

Verification
REQ-034 All three request reads of 0x10/0x20/0x30 in the same cycle: grants are dbg, dat, ifu on cycles 0/1/2; rsp_valid appears on cycles 1/2/3 with matching RAM data.
REQ-035 dat writes 0xDEADBEEF with be=0xF to 0x40, then ifu reads 0x40 the next cycle: ifu_rsp_rdata=0xDEADBEEF, and dat_rsp_rdata=0 for the write.
REQ-036 With the macro on and STARVE_LIMIT=4, dat_req_valid held at 1 and ifu_req_valid held at 1: ifu is granted on the 5th cycle, and the counter returns to 0.
REQ-037 dbg_lock raised during a dat read: the dat response is delivered, dbg_lock_ack rises 1 cycle later, dat/ifu stay at ready=0 for 20 cycles, and ARB resumes the cycle dbg_lock drops.
REQ-038 rst asserted in the cycle after an accepted ifu read: ifu_rsp_valid stays 0, and all outputs hold their reset values per REQ-027.
